// File: rtl/multi_cycle_control_if.sv
// Control bus between the multi-cycle controller and its datapath.
// master: the controller (drives control strobes, reads datapath status).
// slave:  the datapath side (drives opcode/status, reads control strobes).
interface multi_cycle_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       AluResMsb;
    logic       MemReady;

    logic       PcWr;
    logic       IrWr;
    logic       IorD;
    logic       MemRd;
    logic       MemWr;
    logic       MemtoReg;
    logic       RegWr;
    logic       RegDst;
    logic       ExtOp;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] AluOp;
    logic [1:0] PcSrc;
    logic       InstrDone;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Opcode, Zero, AluResMsb, MemReady,
        output PcWr, IrWr, IorD, MemRd, MemWr, MemtoReg, RegWr, RegDst,
               ExtOp, AluSrcA, AluSrcB, AluOp, PcSrc, InstrDone, Illegal, State
    );

    modport slave (
        output Opcode, Zero, AluResMsb, MemReady,
        input  PcWr, IrWr, IorD, MemRd, MemWr, MemtoReg, RegWr, RegDst,
               ExtOp, AluSrcA, AluSrcB, AluOp, PcSrc, InstrDone, Illegal, State
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style controller: Moore FSM sequencing fetch, decode,
// execute, memory and write-back for R-type, addi, lw, sw and branches.
// Optional feature macro BGTZ_EN: when defined, opcode 000111 (bgtz) is
// decoded as a branch; otherwise it is treated as an illegal opcode.
// While rst_n is low every output, including State, is held at zero.
module multi_cycle_control (
    input  logic                  clk,
    input  logic                  rst_n,
    multi_cycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
`ifdef BGTZ_EN
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
`else
    // bgtz gating is absent in this build, so the sign bit has no consumer.
    logic unused_alu_res_msb;
    assign unused_alu_res_msb = bus.AluResMsb;
`endif

    state_t     state_q, state_d;
    logic       pc_wr, ir_wr, iord, mem_rd, mem_wr, mem_to_reg;
    logic       reg_wr, reg_dst, ext_op, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;

    // State register; reset returns to FETCH and abandons any instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and per-state control decode; unused codes fall back to FETCH.
    always_comb begin
        state_d    = S_FETCH;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        ext_op     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                // Instruction and PC+4 are captured only once memory delivers.
                ir_wr     = bus.MemReady;
                pc_wr     = bus.MemReady;
                state_d   = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                case (bus.Opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ,
                    OP_BNE:       state_d = S_BRANCH;
`ifdef BGTZ_EN
                    OP_BGTZ:      state_d = S_BRANCH;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX, S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                if (state_q == S_ADDIEX)     state_d = S_ADDIWB;
                else if (bus.Opcode == OP_SW) state_d = S_MEMWR;
                else                          state_d = S_MEMRD;
            end
            S_ADDIWB: begin
                reg_wr     = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                mem_rd  = 1'b1;
                state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_wr     = 1'b1;
                instr_done = bus.MemReady;
                state_d    = bus.MemReady ? S_FETCH : S_MEMWR;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                instr_done = 1'b1;
                // Branch decision comes straight from the ALU compare flags.
                case (bus.Opcode)
                    OP_BEQ:  pc_wr = bus.Zero;
                    OP_BNE:  pc_wr = ~bus.Zero;
`ifdef BGTZ_EN
                    OP_BGTZ: pc_wr = ~bus.Zero & ~bus.AluResMsb;
`endif
                    default: pc_wr = 1'b0;
                endcase
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Hold every output low while reset is asserted so no write can slip out.
    assign bus.PcWr      = rst_n & pc_wr;
    assign bus.IrWr      = rst_n & ir_wr;
    assign bus.IorD      = rst_n & iord;
    assign bus.MemRd     = rst_n & mem_rd;
    assign bus.MemWr     = rst_n & mem_wr;
    assign bus.MemtoReg  = rst_n & mem_to_reg;
    assign bus.RegWr     = rst_n & reg_wr;
    assign bus.RegDst    = rst_n & reg_dst;
    assign bus.ExtOp     = rst_n & ext_op;
    assign bus.AluSrcA   = rst_n & alu_src_a;
    assign bus.AluSrcB   = rst_n ? alu_src_b : 2'b00;
    assign bus.AluOp     = rst_n ? alu_op : 2'b00;
    assign bus.PcSrc     = rst_n ? pc_src : 2'b00;
    assign bus.InstrDone = rst_n & instr_done;
    assign bus.Illegal   = rst_n & illegal;
    assign bus.State     = rst_n ? state_q : 4'd0;
endmodule
